// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits of a WIDTH-bit a+b+ci or a-b-ci per
// clock, carry held in a register, valid/ready handshake on both sides.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NDIG = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_adder: WIDTH and DIGIT must be >= 1 and DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             step;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_carry;
    logic             carry_into_msb;

    // NOTE: async reset in the sensitivity list; state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One DIGIT-wide ripple slice; the carry into the slice MSB is recovered
    // from the MSB sum bit, which gives the signed-overflow term on the last digit.
    always_comb begin
        dig_a                  = a_q[int'(cnt) * DIGIT +: DIGIT];
        dig_b                  = b_q[int'(cnt) * DIGIT +: DIGIT];
        {dig_carry, dig_sum}   = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
        carry_into_msb         = dig_sum[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            // Subtraction is a + ~b + !ci, so B is inverted here and the carry seeded with ci ^ sub.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= ci ^ sub;
            cnt     <= '0;
        end else if (step) begin
            sum_q[int'(cnt) * DIGIT +: DIGIT] <= dig_sum;
            carry_q                           <= dig_carry;
            if (cnt == LAST) begin
                cout_q <= dig_carry;
                ovf_q  <= carry_into_msb ^ dig_carry;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: main (8,2) instance plus (8,1), (8,8)
// and (16,4) instances for the parameter sweep.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // (8,2) instance
    logic       in_valid, in_ready, ci, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;
    // (8,1) instance
    logic       in_valid_1, in_ready_1, ci_1, sub_1, out_valid_1, cout_1, ovf_1;
    logic [7:0] a_1, b_1, sum_1;
    // (8,8) instance
    logic       in_valid_8, in_ready_8, ci_8, sub_8, out_valid_8, cout_8, ovf_8;
    logic [7:0] a_8, b_8, sum_8;
    // (16,4) instance
    logic        in_valid_16, in_ready_16, ci_16, sub_16, out_valid_16, cout_16, ovf_16;
    logic [15:0] a_16, b_16, sum_16;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf));

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1), .a(a_1), .b(b_1),
        .ci(ci_1), .sub(sub_1), .out_valid(out_valid_1), .out_ready(1'b1), .sum(sum_1),
        .cout(cout_1), .ovf(ovf_1));

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .a(a_8), .b(b_8),
        .ci(ci_8), .sub(sub_8), .out_valid(out_valid_8), .out_ready(1'b1), .sum(sum_8),
        .cout(cout_8), .ovf(ovf_8));

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_16), .in_ready(in_ready_16), .a(a_16), .b(b_16),
        .ci(ci_16), .sub(sub_16), .out_valid(out_valid_16), .out_ready(1'b1), .sum(sum_16),
        .cout(cout_16), .ovf(ovf_16));

    // Drivers (no checking). All run from posedge+1 and return at posedge+1.
    task automatic start_op(input logic [7:0] aa, input logic [7:0] bb, input logic cc, input logic ss);
        int n = 0;
        a = aa; b = bb; ci = cc; sub = ss; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_w8(input bit use_d1, input logic [7:0] aa, input logic [7:0] bb,
                          input logic cc, input logic ss,
                          output logic [7:0] rs, output logic rc, output logic ro, output int lat);
        if (use_d1) begin
            a_1 = aa; b_1 = bb; ci_1 = cc; sub_1 = ss; in_valid_1 = 1'b1;
        end else begin
            a_8 = aa; b_8 = bb; ci_8 = cc; sub_8 = ss; in_valid_8 = 1'b1;
        end
        @(posedge clk); #1;
        in_valid_1 = 1'b0;
        in_valid_8 = 1'b0;
        lat = 0;
        while (!(use_d1 ? out_valid_1 : out_valid_8) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = use_d1 ? sum_1 : sum_8;
        rc = use_d1 ? cout_1 : cout_8;
        ro = use_d1 ? ovf_1 : ovf_8;
        @(posedge clk); #1;
    endtask

    task automatic run_w16(input logic [15:0] aa, input logic [15:0] bb, input logic cc, input logic ss,
                           output logic [15:0] rs, output logic rc, output logic ro, output int lat);
        a_16 = aa; b_16 = bb; ci_16 = cc; sub_16 = ss; in_valid_16 = 1'b1;
        @(posedge clk); #1;
        in_valid_16 = 1'b0;
        lat = 0;
        while (!out_valid_16 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum_16; rc = cout_16; ro = ovf_16;
        @(posedge clk); #1;
    endtask

    // Reference: unsigned 17-bit arithmetic for sum/carry, signed integers for overflow.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
        int          sx, sy, r;
        logic [16:0] u;
        logic        o;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            u = {1'b0, x} + {1'b0, y} + 17'(c);
            r = sx + sy + int'(c);
        end else begin
            u = {1'b0, x} - {1'b0, y} - 17'(c);
            r = sx - sy - int'(c);
        end
        o = (r > 32767) || (r < -32768);
        // For subtraction u[16] is a borrow; cout reports "no borrow".
        return {o, s ? ~u[16] : u[16], u[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; ci_1 = 1'b0; sub_1 = 1'b0;
        in_valid_8 = 1'b0; a_8 = '0; b_8 = '0; ci_8 = 1'b0; sub_8 = 1'b0;
        in_valid_16 = 1'b0; a_16 = '0; b_16 = '0; ci_16 = 1'b0; sub_16 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_handshake: in_ready/out_valid=%b expected 10", {in_ready, out_valid});
        end
        checks++;
        if ({sum, cout, ovf} !== 10'h000) begin
            errors++;
            $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b expected 00 0 0", sum, cout, ovf);
        end
        checks++;
        if ({in_ready_1, out_valid_1, in_ready_8, out_valid_8, in_ready_16, out_valid_16} !== 6'b101010) begin
            errors++;
            $display("FAIL reset_sweep_instances: got %b expected 101010",
                     {in_ready_1, out_valid_1, in_ready_8, out_valid_8, in_ready_16, out_valid_16});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        logic [7:0] va[5], vb[5], es[5];
        logic       vc[5], vs[5], ec[5], eo[5];
        int         lat;
        logic [7:0] held;
        va = '{8'hFF, 8'h05, 8'h07, 8'h7F, 8'h80};
        vb = '{8'h01, 8'h07, 8'h05, 8'h01, 8'h01};
        vc = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        vs = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        es = '{8'h00, 8'hFE, 8'h01, 8'h80, 8'h7F};
        ec = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        eo = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vc[i], vs[i]);
            wait_done(lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL add_sub_latency[%0d]: %0d cycles expected 4", i, lat);
            end
            checks++;
            if ({sum, cout, ovf} !== {es[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL add_sub_result[%0d]: sum=%h cout=%b ovf=%b expected %h %b %b",
                         i, sum, cout, ovf, es[i], ec[i], eo[i]);
            end
            held = sum;
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, sum} !== {2'b01, es[i]}) begin
                errors++;
                $display("FAIL add_sub_one_cycle_valid[%0d]: out_valid=%b in_ready=%b sum=%h expected 0 1 %h",
                         i, out_valid, in_ready, sum, held);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        start_op(8'h12, 8'h34, 1'b1, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL backpressure_latency: %0d cycles expected 4", lat);
        end
        for (int i = 0; i < 5; i++) begin
            a = 8'hFF; b = 8'hFF; ci = 1'b1; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if ({out_valid, in_ready, sum, cout, ovf} !== {2'b10, 8'h47, 2'b00}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b expected 1 0 47 0 0",
                         i, out_valid, in_ready, sum, cout, ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, sum} !== {2'b10, 8'h47}) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b sum=%h expected 1 0 47",
                     in_ready, out_valid, sum);
        end
        start_op(8'h01, 8'h01, 1'b0, 1'b0);
        wait_done(lat);
        checks++;
        if ({sum, cout, ovf} !== {8'h02, 2'b00}) begin
            errors++;
            $display("FAIL backpressure_next_op: sum=%h cout=%b ovf=%b expected 02 0 0", sum, cout, ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit seen_valid = 1'b0;
        start_op(8'hAA, 8'h55, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (sum !== 8'h0F) begin
            errors++;
            $display("FAIL mid_run_partial_sum: sum=%h expected 0f", sum);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {2'b10, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL mid_run_async_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b expected 1 0 00 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid || !in_ready) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL mid_run_no_emit: aborted operation produced out_valid or cleared in_ready (seen=1 expected 0)");
        end
        start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 4 || {sum, cout, ovf} !== {8'h4B, 2'b00}) begin
            errors++;
            $display("FAIL mid_run_recovery: lat=%0d sum=%h cout=%b ovf=%b expected 4 4b 0 0", lat, sum, cout, ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_digit1();
        logic [7:0] rs;
        logic       rc, ro;
        int         lat;
        run_w8(1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, rs, rc, ro, lat);
        checks++;
        if (lat !== 8 || {rs, rc, ro} !== {8'hE1, 2'b00}) begin
            errors++;
            $display("FAIL digit1_add: lat=%0d sum=%h cout=%b ovf=%b expected 8 e1 0 0", lat, rs, rc, ro);
        end
        run_w8(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, rs, rc, ro, lat);
        checks++;
        if (lat !== 8 || {rs, rc, ro} !== {8'hF0, 2'b00}) begin
            errors++;
            $display("FAIL digit1_sub: lat=%0d sum=%h cout=%b ovf=%b expected 8 f0 0 0", lat, rs, rc, ro);
        end
    endtask

    task automatic test_digit8();
        logic [7:0] rs;
        logic       rc, ro;
        int         lat;
        run_w8(1'b0, 8'h7F, 8'h7F, 1'b1, 1'b0, rs, rc, ro, lat);
        checks++;
        if (lat !== 1 || {rs, rc, ro} !== {8'hFF, 2'b01}) begin
            errors++;
            $display("FAIL digit8_add: lat=%0d sum=%h cout=%b ovf=%b expected 1 ff 0 1", lat, rs, rc, ro);
        end
        run_w8(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, rs, rc, ro, lat);
        checks++;
        if (lat !== 1 || {rs, rc, ro} !== {8'hFF, 2'b00}) begin
            errors++;
            $display("FAIL digit8_sub: lat=%0d sum=%h cout=%b ovf=%b expected 1 ff 0 0", lat, rs, rc, ro);
        end
    endtask

    task automatic test_random16();
        logic [15:0] ra, rb, rs;
        logic        rcin, rsub, rc, ro;
        logic [17:0] exp_v;
        int          lat;
        logic [15:0] da[4], db[4];
        logic        dc[4], ds[4];
        da = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
        db = '{16'h0001, 16'h0001, 16'h0000, 16'h0000};
        dc = '{1'b0, 1'b0, 1'b1, 1'b1};
        ds = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 1000; i++) begin
            if (i < 4) begin
                ra = da[i]; rb = db[i]; rcin = dc[i]; rsub = ds[i];
            end else begin
                ra = 16'($urandom); rb = 16'($urandom);
                rcin = 1'($urandom_range(1)); rsub = 1'($urandom_range(1));
            end
            run_w16(ra, rb, rcin, rsub, rs, rc, ro, lat);
            exp_v = model16(ra, rb, rcin, rsub);
            checks++;
            if (lat !== 4 || {ro, rc, rs} !== exp_v) begin
                errors++;
                $display("FAIL random16[%0d]: a=%h b=%h ci=%b sub=%b lat=%0d sum=%h cout=%b ovf=%b expected lat 4 sum=%h cout=%b ovf=%b",
                         i, ra, rb, rcin, rsub, lat, rs, rc, ro, exp_v[15:0], exp_v[16], exp_v[17]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_backpressure();
        test_reset_mid_run();
        test_digit1();
        test_digit8();
        test_random16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
